// File: rtl/spi_ram_slave_burst.sv
// rtl/spi_ram_slave_burst.sv - SPI slave owning a single-port RAM, with address/data commands and auto-increment bursts
module spi_ram_slave_burst #(
  parameter int ADDR_SIZE  = 8,
  parameter int MEM_DEPTH  = 256,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_EN   = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic MOSI,
  input  logic SS_n,
  output logic MISO,
  output logic busy,
  output logic frame_err
);

  localparam int SW = (ADDR_SIZE > DATA_WIDTH) ? ADDR_SIZE : DATA_WIDTH;
  localparam int CW = $clog2(SW + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, DRAIN
  } state_t;

  state_t                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [SW-2:0]           shin, shin_n;
  logic [SW-1:0]           shifted;
  logic                    c1, c1_n;
  logic [DATA_WIDTH-1:0]   out_sr, out_n;
  logic                    loaded, loaded_n;
  logic [ADDR_SIZE-1:0]    wr_addr, wr_addr_n;
  logic [ADDR_SIZE-1:0]    rd_addr, rd_addr_n;
  logic                    err_n;
  logic                    hold, hold_n;

  logic [DATA_WIDTH-1:0]   mem [0:MEM_DEPTH-1];
  logic [DATA_WIDTH-1:0]   mem_q;
  logic                    we, re;
  logic [ADDR_SIZE-1:0]    ram_addr;
  logic [DATA_WIDTH-1:0]   wdata;

  assign shifted = {shin, MOSI};
  assign wdata   = shifted[DATA_WIDTH-1:0];
  assign busy    = (state != IDLE);
  assign MISO    = (state == RD_DATA) ? out_sr[DATA_WIDTH-1] : 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      shin      <= '0;
      c1        <= 1'b0;
      out_sr    <= '0;
      loaded    <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      frame_err <= 1'b0;
      // a frame cut by reset must see SS_n high before a new one starts
      hold      <= 1'b1;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      shin      <= shin_n;
      c1        <= c1_n;
      out_sr    <= out_n;
      loaded    <= loaded_n;
      wr_addr   <= wr_addr_n;
      rd_addr   <= rd_addr_n;
      frame_err <= err_n;
      hold      <= hold_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    shin_n    = shin;
    c1_n      = c1;
    out_n     = out_sr;
    loaded_n  = loaded;
    wr_addr_n = wr_addr;
    rd_addr_n = rd_addr;
    err_n     = 1'b0;
    hold_n    = hold;
    we        = 1'b0;
    re        = 1'b0;
    ram_addr  = wr_addr;

    if (SS_n) begin
      state_n  = IDLE;
      cnt_n    = '0;
      out_n    = '0;
      loaded_n = 1'b0;
      hold_n   = 1'b0;
      case (state)
        CMD:                                    err_n = 1'b1;
        WR_ADDR, RD_ADDR, WR_DATA, RD_DATA:     err_n = (cnt != '0);
        default:                                err_n = 1'b0;
      endcase
    end else begin
      case (state)
        IDLE: begin
          if (!hold) begin
            c1_n    = MOSI;
            state_n = CMD;
          end
        end
        CMD: begin
          cnt_n = '0;
          case ({c1, MOSI})
            2'b00:   state_n = WR_ADDR;
            2'b01:   state_n = WR_DATA;
            2'b10:   state_n = RD_ADDR;
            default: begin
              state_n  = RD_DATA;
              re       = 1'b1;
              ram_addr = rd_addr;
              out_n    = '0;
              loaded_n = 1'b0;
            end
          endcase
        end
        WR_ADDR, RD_ADDR: begin
          shin_n = shifted[SW-2:0];
          if (cnt == CW'(ADDR_SIZE - 1)) begin
            if (state == WR_ADDR) wr_addr_n = shifted[ADDR_SIZE-1:0];
            else                  rd_addr_n = shifted[ADDR_SIZE-1:0];
            cnt_n   = '0;
            state_n = DRAIN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        WR_DATA: begin
          shin_n = shifted[SW-2:0];
          if (cnt == CW'(DATA_WIDTH - 1)) begin
            we        = 1'b1;
            ram_addr  = wr_addr;
            wr_addr_n = wr_addr + 1'b1;
            cnt_n     = '0;
            if (BURST_EN == 0) state_n = DRAIN;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        RD_DATA: begin
          // cnt == 0 marks a word boundary: load the prefetched word and fetch the next
          if (cnt == '0) begin
            if (BURST_EN == 0 && loaded) begin
              state_n = DRAIN;
              out_n   = '0;
            end else begin
              out_n     = mem_q;
              rd_addr_n = rd_addr + 1'b1;
              re        = 1'b1;
              ram_addr  = rd_addr + 1'b1;
              loaded_n  = 1'b1;
              cnt_n     = CW'(DATA_WIDTH - 1);
            end
          end else begin
            out_n = {out_sr[DATA_WIDTH-2:0], 1'b0};
            cnt_n = cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[ram_addr] <= wdata;
    if (re) mem_q <= mem[ram_addr];
  end

endmodule
